store_queue: RTL and testbench
==============================

Name: store_queue

Overview:
Parametrised circular store queue, the next generation of the single-entry store-queue slot. It holds DEPTH in-flight stores from dispatch until dcache write. Entries are filled out of order by AGU (address) and DGU (data) writeback, and marked committed in order by ROB commit count. Committed entries drain in order to the dcache over a valid/ready port. Flush discards only uncommitted entries; committed stores survive and keep draining.

Parameters:
DEPTH, 16, number of entries; power of two, at least 2
ROBID_W, 7, ROB id width including wrap bit
ADDR_W, 64, store address width
DATA_W, 64, store data width; mask width is DATA_W
COMMIT_W, 2, maximum stores committed per cycle
IDX_W, $clog2(DEPTH), entry index width (derived)

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
enq_valid  in  1  dispatch offers a store
enq_robid  in  ROBID_W  ROB id of the offered store
enq_ready  out  1  queue can accept; equals ~full & ~flush
enq_idx  out  IDX_W  slot the offered store lands in (tail index)
agu_valid  in  1  address writeback
agu_idx  in  IDX_W  target slot
agu_addr  in  ADDR_W  store address
agu_mmio  in  1  address is MMIO
dgu_valid  in  1  data writeback
dgu_idx  in  IDX_W  target slot
dgu_data  in  DATA_W  store data
dgu_mask  in  DATA_W  byte/bit mask
dgu_size  in  4  access size code
commit_cnt  in  $clog2(COMMIT_W+1)  stores retired by ROB this cycle
flush  in  1  pipeline flush
dc_req_valid  out  1  head store ready for dcache
dc_req_ready  in  1  dcache accepts
dc_req_addr, dc_req_data, dc_req_mask, dc_req_size, dc_req_mmio, dc_req_robid  out  ADDR_W/DATA_W/DATA_W/4/1/ROBID_W  head entry fields
count  out  IDX_W+1  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Pointers head, cmt and tail are each IDX_W+1 bits with a wrap bit. Invariant: head <= cmt <= tail, modulo arithmetic.
- count = tail - head.
- Reset:
  - head, cmt and tail are 0.
  - All valid, complete, data_valid, mmio and committed flags are 0; all payload fields are 0.
  - dc_req_valid = 0, empty = 1, full = 0, count = 0, enq_idx = 0.
- Enqueue: when enq_valid & enq_ready, on the next edge:
  - slot[tail] gets valid = 1 and robid latched;
  - slot[tail] gets complete = data_valid = mmio = 0;
  - tail increments.
  - enq_valid while not ready is dropped, and the producer must hold it.
- AGU writeback: sets addr, mmio and complete on slot agu_idx. Ignored if the slot is not valid.
- DGU writeback: sets data, mask, size and data_valid on slot dgu_idx. Ignored if the slot is not valid.
- AGU and DGU writeback to the same slot in the same cycle both apply.
- Commit: cmt += commit_cnt. Requires cmt + commit_cnt <= tail; a violation is a bench assertion failure.
- Drain:
  - dc_req_valid = (head != cmt) & slot[head].complete & slot[head].data_valid. It is combinational from registered state, so there is no extra latency.
  - dc_req_* present slot[head] fields.
  - On dc_req_valid & dc_req_ready: slot[head].valid clears and head increments at the edge.
  - MMIO entries use the same port with dc_req_mmio = 1, strictly in order.
- Latency: a slot is eligible to drain the cycle after the last of its AGU, DGU or commit events.
- Flush: at the edge, tail <= cmt + commit_cnt.
  - Same-cycle commit applies first.
  - Slots from the new tail up to the old tail clear valid.
  - Head, committed slots and a same-cycle dequeue are unaffected.
  - enq_ready = 0 during flush, so no enqueue happens.
- Simultaneous enqueue and dequeue when full: enq_ready is still 0 (full is registered state). There is no bypass.
- Wrap-around: index = pointer[IDX_W-1:0]. full/empty are distinguished by the wrap bit.
- Reset asserted mid-operation: immediate return to the reset state. In-flight dcache handshake is abandoned.

Test Plan:
- Reset, enqueue 3 stores (robid 5,6,7) -> enq_idx 0,1,2; count=3; dc_req_valid=0.
- AGU/DGU slot 0 (addr 0x1000, data 0xAB, mask 0xFF), commit_cnt=1, dc_req_ready=1 -> dc_req_valid=1 the next cycle with addr 0x1000; head advances to 1; count=2.
- Fill all 16 slots -> full=1, enq_ready=0; a 17th enq_valid is not accepted. Drain one -> enq_idx=0 on wrap; full=0.
- Enqueue 6, commit 2, flush in the same cycle as commit_cnt=1 -> tail=3, count=3; slots 3-5 invalid; slots 0-2 still drain in order.
- Slot 1 complete but slot 0 not -> dc_req_valid=0 (in-order). Completing slot 0 -> drains 0 then 1 in back-to-back cycles.
- MMIO store at head (agu_mmio=1) -> dc_req_mmio=1; dc_req_ready held 0 for 4 cycles -> request stays stable; head unchanged.

Source files
------------

// File: rtl/store_queue.sv
// store_queue
//   Circular store queue holding DEPTH in-flight stores from dispatch until
//   they are written to the dcache. Entries are allocated in order at the
//   tail, filled out of order by AGU (address) and DGU (data) writeback,
//   committed in order by the ROB, and drained in order from the head.
//   A flush discards only uncommitted entries; committed stores keep draining.
//
// Ports
//   clock, reset_n          clock, asynchronous active-low reset
//   enq_*                   dispatch allocation (enq_idx = slot the store lands in)
//   agu_*                   address writeback to slot agu_idx
//   dgu_*                   data/mask/size writeback to slot dgu_idx
//   commit_cnt              number of stores retired by the ROB this cycle
//   flush                   discard uncommitted entries
//   dc_req_*                head entry offered to the dcache (valid/ready)
//   count, full, empty      occupancy status
module store_queue #(
  parameter int DEPTH    = 16,
  parameter int ROBID_W  = 7,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int COMMIT_W = 2,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enq_valid,
  input  logic [ROBID_W-1:0]             enq_robid,
  output logic                           enq_ready,
  output logic [IDX_W-1:0]               enq_idx,
  input  logic                           agu_valid,
  input  logic [IDX_W-1:0]               agu_idx,
  input  logic [ADDR_W-1:0]              agu_addr,
  input  logic                           agu_mmio,
  input  logic                           dgu_valid,
  input  logic [IDX_W-1:0]               dgu_idx,
  input  logic [DATA_W-1:0]              dgu_data,
  input  logic [DATA_W-1:0]              dgu_mask,
  input  logic [3:0]                     dgu_size,
  input  logic [$clog2(COMMIT_W+1)-1:0]  commit_cnt,
  input  logic                           flush,
  output logic                           dc_req_valid,
  input  logic                           dc_req_ready,
  output logic [ADDR_W-1:0]              dc_req_addr,
  output logic [DATA_W-1:0]              dc_req_data,
  output logic [DATA_W-1:0]              dc_req_mask,
  output logic [3:0]                     dc_req_size,
  output logic                           dc_req_mmio,
  output logic [ROBID_W-1:0]             dc_req_robid,
  output logic [IDX_W:0]                 count,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = IDX_W + 1;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] cmt_q, cmt_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] complete_q, complete_d;
  logic [DEPTH-1:0] dvalid_q, dvalid_d;
  logic [DEPTH-1:0] mmio_q, mmio_d;

  logic [ROBID_W-1:0] robid_q [DEPTH];
  logic [ROBID_W-1:0] robid_d [DEPTH];
  logic [ADDR_W-1:0]  addr_q  [DEPTH];
  logic [ADDR_W-1:0]  addr_d  [DEPTH];
  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [DATA_W-1:0]  data_d  [DEPTH];
  logic [DATA_W-1:0]  mask_q  [DEPTH];
  logic [DATA_W-1:0]  mask_d  [DEPTH];
  logic [3:0]         size_q  [DEPTH];
  logic [3:0]         size_d  [DEPTH];

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             enq_fire;
  logic             deq_fire;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign count     = tail_q - head_q;
  assign full      = (count == PTR_W'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = ~full & ~flush;
  assign enq_idx   = tail_idx;
  assign enq_fire  = enq_valid & enq_ready;

  // Only committed entries may leave; the head must also have both halves.
  assign dc_req_valid = (head_q != cmt_q) & complete_q[head_idx] & dvalid_q[head_idx];
  assign deq_fire     = dc_req_valid & dc_req_ready;

  assign dc_req_addr  = addr_q[head_idx];
  assign dc_req_data  = data_q[head_idx];
  assign dc_req_mask  = mask_q[head_idx];
  assign dc_req_size  = size_q[head_idx];
  assign dc_req_mmio  = mmio_q[head_idx];
  assign dc_req_robid = robid_q[head_idx];

  // Commit is applied before flush, so a flush truncates the queue right
  // after the newly committed entries.
  assign cmt_d  = cmt_q + PTR_W'(commit_cnt);
  assign head_d = head_q + PTR_W'(deq_fire);
  assign tail_d = flush ? cmt_d : (tail_q + PTR_W'(enq_fire));

  logic [PTR_W-1:0] uncmt;
  logic [IDX_W-1:0] off;

  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    dvalid_d   = dvalid_q;
    mmio_d     = mmio_q;
    robid_d    = robid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    size_d     = size_q;
    uncmt      = tail_q - cmt_d;
    off        = '0;

    // Writebacks to slots that are not allocated are stale and dropped.
    if (agu_valid && valid_q[agu_idx]) begin
      addr_d[agu_idx]     = agu_addr;
      mmio_d[agu_idx]     = agu_mmio;
      complete_d[agu_idx] = 1'b1;
    end
    if (dgu_valid && valid_q[dgu_idx]) begin
      data_d[dgu_idx]   = dgu_data;
      mask_d[dgu_idx]   = dgu_mask;
      size_d[dgu_idx]   = dgu_size;
      dvalid_d[dgu_idx] = 1'b1;
    end

    if (enq_fire) begin
      valid_d[tail_idx]    = 1'b1;
      robid_d[tail_idx]    = enq_robid;
      complete_d[tail_idx] = 1'b0;
      dvalid_d[tail_idx]   = 1'b0;
      mmio_d[tail_idx]     = 1'b0;
    end

    if (deq_fire) begin
      valid_d[head_idx] = 1'b0;
    end

    // A slot is discarded when its distance past the post-commit pointer
    // falls inside the uncommitted window [cmt_d, tail_q).
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = IDX_W'(i) - cmt_d[IDX_W-1:0];
        if ({1'b0, off} < uncmt) begin
          valid_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      cmt_q      <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      complete_q <= '0;
      dvalid_q   <= '0;
      mmio_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        robid_q[i] <= '0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        mask_q[i]  <= '0;
        size_q[i]  <= '0;
      end
    end else begin
      head_q     <= head_d;
      cmt_q      <= cmt_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      complete_q <= complete_d;
      dvalid_q   <= dvalid_d;
      mmio_q     <= mmio_d;
      robid_q    <= robid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      size_q     <= size_d;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enq_valid = 1'b0;
  logic [6:0]  enq_robid = '0;
  logic        enq_ready;
  logic [3:0]  enq_idx;
  logic        agu_valid = 1'b0;
  logic [3:0]  agu_idx = '0;
  logic [63:0] agu_addr = '0;
  logic        agu_mmio = 1'b0;
  logic        dgu_valid = 1'b0;
  logic [3:0]  dgu_idx = '0;
  logic [63:0] dgu_data = '0;
  logic [63:0] dgu_mask = '0;
  logic [3:0]  dgu_size = '0;
  logic [1:0]  commit_cnt = '0;
  logic        flush = 1'b0;
  logic        dc_req_valid;
  logic        dc_req_ready = 1'b0;
  logic [63:0] dc_req_addr;
  logic [63:0] dc_req_data;
  logic [63:0] dc_req_mask;
  logic [3:0]  dc_req_size;
  logic        dc_req_mmio;
  logic [6:0]  dc_req_robid;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  store_queue dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_robid(enq_robid), .enq_ready(enq_ready), .enq_idx(enq_idx),
    .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr), .agu_mmio(agu_mmio),
    .dgu_valid(dgu_valid), .dgu_idx(dgu_idx), .dgu_data(dgu_data), .dgu_mask(dgu_mask),
    .dgu_size(dgu_size), .commit_cnt(commit_cnt), .flush(flush),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask), .dc_req_size(dc_req_size),
    .dc_req_mmio(dc_req_mmio), .dc_req_robid(dc_req_robid),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] mask;
    logic [3:0]  size;
    logic        mmio;
    logic [6:0]  robid;
  } req_t;

  req_t exp_q[$];
  req_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_drained = 0;
  int   b_rob[DEPTH];
  int   b_tail = 0;
  int   b_cmt = 0;
  bit   mmio_of[128];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] f_addr(input int r);
    return 64'h1000 + (64'(r - 5) << 4);
  endfunction
  function automatic logic [63:0] f_data(input int r);
    return 64'hAB + 64'(r - 5) * 64'h100;
  endfunction
  function automatic logic [63:0] f_mask(input int r);
    return 64'hFF << (8 * ((r - 5) % 8));
  endfunction

  // Dcache side: every accepted request must be the oldest committed store.
  always @(negedge clock) begin
    if (reset_n && dc_req_valid && dc_req_ready) begin
      if (exp_q.size() == 0) begin
        chk("drain_unexpected", 64'(dc_req_robid), 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dc_robid", 64'(dc_req_robid), 64'(mon_e.robid));
        chk("dc_addr", dc_req_addr, mon_e.addr);
        chk("dc_data", dc_req_data, mon_e.data);
        chk("dc_mask", dc_req_mask, mon_e.mask);
        chk("dc_size", 64'(dc_req_size), 64'(mon_e.size));
        chk("dc_mmio", 64'(dc_req_mmio), 64'(mon_e.mmio));
      end
      n_drained++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    enq_valid  = 1'b0;
    agu_valid  = 1'b0;
    dgu_valid  = 1'b0;
    commit_cnt = '0;
    flush      = 1'b0;
    #1;
  endtask

  task automatic do_reset(input bit check_async);
    reset_n = 1'b0;
    dc_req_ready = 1'b0;
    enq_valid = 1'b0; agu_valid = 1'b0; dgu_valid = 1'b0;
    commit_cnt = '0; flush = 1'b0;
    #1;
    if (check_async) begin
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_dc_valid", 64'(dc_req_valid), 64'd0);
    end
    @(posedge clock);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_enq_idx", 64'(enq_idx), 64'd0);
    chk("rst_dc_valid", 64'(dc_req_valid), 64'd0);
    exp_q.delete();
    b_tail = 0;
    b_cmt = 0;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic enq(input int r, input int exp_idx);
    chk("enq_ready", 64'(enq_ready), 64'd1);
    chk("enq_idx", 64'(enq_idx), 64'(exp_idx));
    enq_valid = 1'b1;
    enq_robid = 7'(r);
    b_rob[b_tail % DEPTH] = r;
    b_tail++;
    step();
  endtask

  task automatic wb(input int slot);
    int r;
    r = b_rob[slot];
    agu_valid = 1'b1; agu_idx = 4'(slot); agu_addr = f_addr(r); agu_mmio = mmio_of[r];
    dgu_valid = 1'b1; dgu_idx = 4'(slot); dgu_data = f_data(r);
    dgu_mask = f_mask(r); dgu_size = 4'(r);
    step();
  endtask

  task automatic push_commits(input int n);
    req_t e;
    int r;
    assert (b_cmt + n <= b_tail) else $error("FAIL commit_beyond_tail cmt=%0d n=%0d tail=%0d", b_cmt, n, b_tail);
    for (int k = 0; k < n; k++) begin
      r = b_rob[b_cmt % DEPTH];
      e.addr = f_addr(r); e.data = f_data(r); e.mask = f_mask(r);
      e.size = 4'(r); e.mmio = mmio_of[r]; e.robid = 7'(r);
      exp_q.push_back(e);
      b_cmt++;
    end
  endtask

  task automatic commit(input int n);
    push_commits(n);
    commit_cnt = 2'(n);
    step();
  endtask

  task automatic flush_commit(input int n);
    push_commits(n);
    commit_cnt = 2'(n);
    flush = 1'b1;
    enq_valid = 1'b1;
    enq_robid = 7'd99;
    #1;
    chk("flush_enq_ready", 64'(enq_ready), 64'd0);
    step();
    b_tail = b_cmt;
  endtask

  task automatic wait_drain(input int n, input int budget);
    int tgt;
    int k;
    tgt = n_drained + n;
    k = 0;
    while (n_drained < tgt && k < budget) begin
      step();
      k++;
    end
    chk("drain_done", 64'(n_drained), 64'(tgt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mmio_of[i] = 1'b0;
    for (int i = 0; i < DEPTH; i++) b_rob[i] = 0;

    // Basic enqueue.
    do_reset(1'b0);
    enq(5, 0);
    enq(6, 1);
    enq(7, 2);
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_dc_valid", 64'(dc_req_valid), 64'd0);

    // Complete and commit the head store; it drains next cycle.
    dc_req_ready = 1'b1;
    wb(0);
    chk("t2_uncommitted_valid", 64'(dc_req_valid), 64'd0);
    commit(1);
    chk("t2_dc_valid", 64'(dc_req_valid), 64'd1);
    chk("t2_dc_addr", dc_req_addr, 64'h1000);
    step();
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_dc_valid_after", 64'(dc_req_valid), 64'd0);

    // Mid-operation reset, then fill to full and wrap.
    do_reset(1'b1);
    for (int i = 0; i < DEPTH; i++) enq(10 + i, i);
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_enq_ready", 64'(enq_ready), 64'd0);
    chk("t3_count", 64'(count), 64'd16);
    enq_valid = 1'b1;
    enq_robid = 7'd99;
    step();
    chk("t3_reject_count", 64'(count), 64'd16);
    chk("t3_reject_idx", 64'(enq_idx), 64'd0);
    dc_req_ready = 1'b1;
    wb(0);
    commit(1);
    wait_drain(1, 10);
    chk("t3_not_full", 64'(full), 64'd0);
    chk("t3_count_15", 64'(count), 64'd15);
    chk("t3_wrap_idx", 64'(enq_idx), 64'd0);
    enq(30, 0);
    chk("t3_full_again", 64'(full), 64'd1);

    // Flush with same-cycle commit keeps committed stores.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) enq(40 + i, i);
    wb(0);
    wb(1);
    wb(2);
    commit(2);
    flush_commit(1);
    chk("t4_count", 64'(count), 64'd3);
    chk("t4_enq_idx", 64'(enq_idx), 64'd3);
    dc_req_ready = 1'b1;
    wait_drain(3, 20);
    chk("t4_empty", 64'(empty), 64'd1);

    // In-order drain: a younger complete store waits for the head.
    enq(60, 3);
    enq(61, 4);
    wb(4);
    commit(2);
    chk("t5_blocked0", 64'(dc_req_valid), 64'd0);
    step();
    chk("t5_blocked1", 64'(dc_req_valid), 64'd0);
    wb(3);
    chk("t5_first_valid", 64'(dc_req_valid), 64'd1);
    chk("t5_first_robid", 64'(dc_req_robid), 64'd60);
    step();
    chk("t5_second_valid", 64'(dc_req_valid), 64'd1);
    chk("t5_second_robid", 64'(dc_req_robid), 64'd61);
    step();
    chk("t5_empty", 64'(empty), 64'd1);

    // MMIO store held by backpressure.
    dc_req_ready = 1'b0;
    mmio_of[70] = 1'b1;
    enq(70, 5);
    wb(5);
    commit(1);
    chk("t6_valid", 64'(dc_req_valid), 64'd1);
    chk("t6_mmio", 64'(dc_req_mmio), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_hold_valid", 64'(dc_req_valid), 64'd1);
      chk("t6_hold_addr", dc_req_addr, f_addr(70));
      chk("t6_hold_count", 64'(count), 64'd1);
    end
    dc_req_ready = 1'b1;
    wait_drain(1, 10);
    chk("t6_empty", 64'(empty), 64'd1);

    chk("exp_left", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
